ddr3_cmd_decoder: RTL and testbench
===================================

Name: ddr3_cmd_decoder

Overview:
- DRAM-side responder for the DDR3 command bus: samples cke/cs_n/ras_n/cas_n/we_n/ba/addr on every rising ck and decodes the command.
- Tracks mode registers MR0-MR3, the initialization sequence, per-bank open/closed state with tRCD/tRP/tMRD timers, and flags protocol violations.
- Sits in the testbench beside the memory model, driven by the same interface signals the host command tasks drive.

Parameters:
BA_BITS, 3, bank address width; NB = 2**BA_BITS banks
ADDR_BITS, 14, address bus width
ROW_BITS, 14, row address width (<= ADDR_BITS)
TRCD, 6, ACT to RD/WR minimum, in ck cycles (>= 1)
TRP, 6, PRE to bank idle, in ck cycles (>= 1)
TMRD, 4, MRS to next MRS/non-NOP, in ck cycles (>= 1)

Ports:
ck  input  1  clock; all sampling on rising edge
rst_n  input  1  asynchronous active-low reset
cke  input  1  clock enable; 0 = no command decoded
cs_n, ras_n, cas_n, we_n  input  1 each  command pins
ba  input  BA_BITS  bank address
addr  input  ADDR_BITS  address bus (A10 = auto-precharge / precharge-all / ZQ long)
cmd_valid  output  1  pulse: a non-NOP/DES command was decoded
cmd_code  output  4  0 MRS, 1 REF, 2 PRE, 3 ACT, 4 WR, 5 RD, 6 ZQ
cmd_ba  output  BA_BITS  registered ba of the decoded command
cmd_addr  output  ADDR_BITS  registered addr of the decoded command
mr0, mr1, mr2, mr3  output  ADDR_BITS each  mode register contents
bank_active  output  NB  bit b = bank b in ACTIVE or ACTIVATING
open_row  output  ROW_BITS  open row of cmd_ba (0 if closed)
init_done  output  1  initialization sequence complete
err_valid  output  1  pulse: the command in cmd_* was illegal
err_code  output  3  1 ACT to non-idle bank, 2 RD/WR to closed bank or inside tRCD, 3 MRS/REF with bank not idle or inside tMRD, 4 illegal command before init_done

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, mode registers 0, all banks IDLE, timers 0, init tracking cleared. Release is synchronous to the next rising ck.
- Decode at rising ck when cke=1. cs_n=1 is DES. {ras_n,cas_n,we_n}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQ, 111 NOP. cke=0 decodes nothing; timers still count.
- Latency: cmd_*, err_*, and updated state appear 1 cycle after the sampling edge. cmd_valid and err_valid are single-cycle pulses.
- Per-bank FSM: IDLE -ACT-> ACTIVATING (timer=TRCD-1) -timer 0-> ACTIVE -PRE-> PRECHARGING (timer=TRP-1) -timer 0-> IDLE.
  - With TRCD=1 or TRP=1, the bank reaches ACTIVE or IDLE directly.
  - ACT at edge n: RD/WR to that bank is legal at edge n+TRCD or later.
  - PRE at edge n: ACT to that bank is legal at edge n+TRP or later.
- PRE rules:
  - A10=1 precharges every bank that is not IDLE.
  - PRE to an IDLE or PRECHARGING bank is legal and has no effect.
  - PRE to an ACTIVATING bank is legal and enters PRECHARGING.
- RD/WR with A10=1 (auto-precharge): after the command, the bank enters PRECHARGING with timer=TRP-1.
- MRS: the addr value is stored into mr[ba[1:0]]; ba[2] is ignored. It loads a tMRD timer with TMRD-1. Any command other than NOP/DES while the tMRD timer is nonzero gives err 3.
- REF: requires all banks IDLE and the tMRD timer at 0, otherwise err 3.
- Init tracking:
  - Before init_done, only MRS, ZQ, NOP and DES are legal; anything else gives err 4.
  - init_done sets one cycle after a ZQ with A10=1 (ZQCL), provided MR0-MR3 have each been written at least once since reset.
  - init_done stays set until reset.
- Errors: an illegal command is still reported on cmd_* with err_valid=1, and bank/mode/init state is not updated. When several errors apply, the lowest err_code is reported.
- open_row reflects the bank addressed by the current cmd_ba. It shows addr[ROW_BITS-1:0] latched at that bank's ACT.

Test Plan:
- Reset mid-ACTIVATING (bank 2, row 0x155): all outputs return to 0 asynchronously, bank_active=0, and the first post-reset RD gives err 4.
- Init: MRS ba=2/3/1/0 with addr 0x008/0x000/0x044/0x1520, each followed by TMRD NOPs, then ZQ A10=1 -> mr0=0x1520, mr1=0x044, mr2=0x008, init_done=1 one cycle after the ZQ.
- After init, ACT ba=3 row=0x1ABC, then RD ba=3 at TRCD-1 cycles (err 2) and at TRCD cycles (no error) -> open_row=0x1ABC, bank_active=0x08.
- ACT ba=1 twice back-to-back -> second gives err 1, and open_row keeps the first row.
- ACT banks 0 and 5, then PRE A10=1 -> bank_active=0 after TRP cycles; REF at TRP-1 gives err 3, at TRP gives no error.
- MRS then MRS after 1 cycle with TMRD=4 -> err 3; mr unchanged by the second write. cke=0 with an ACT pattern on the pins -> no cmd_valid.

Source files
------------

// File: rtl/ddr3_cmd_decoder.sv
// rtl/ddr3_cmd_decoder.sv - DDR3 command bus decoder with bank, mode-register and init tracking
module ddr3_cmd_decoder #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int ROW_BITS  = 14,
  parameter int TRCD      = 6,
  parameter int TRP       = 6,
  parameter int TMRD      = 4
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    cke,
  input  logic                    cs_n,
  input  logic                    ras_n,
  input  logic                    cas_n,
  input  logic                    we_n,
  input  logic [BA_BITS-1:0]      ba,
  input  logic [ADDR_BITS-1:0]    addr,
  output logic                    cmd_valid,
  output logic [3:0]              cmd_code,
  output logic [BA_BITS-1:0]      cmd_ba,
  output logic [ADDR_BITS-1:0]    cmd_addr,
  output logic [ADDR_BITS-1:0]    mr0,
  output logic [ADDR_BITS-1:0]    mr1,
  output logic [ADDR_BITS-1:0]    mr2,
  output logic [ADDR_BITS-1:0]    mr3,
  output logic [2**BA_BITS-1:0]   bank_active,
  output logic [ROW_BITS-1:0]     open_row,
  output logic                    init_done,
  output logic                    err_valid,
  output logic [2:0]              err_code
);

  localparam int NB = 2**BA_BITS;
  localparam int TW = 8;

  localparam logic [3:0] C_MRS = 4'd0;
  localparam logic [3:0] C_REF = 4'd1;
  localparam logic [3:0] C_PRE = 4'd2;
  localparam logic [3:0] C_ACT = 4'd3;
  localparam logic [3:0] C_WR  = 4'd4;
  localparam logic [3:0] C_RD  = 4'd5;
  localparam logic [3:0] C_ZQ  = 4'd6;

  typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bank_state_e;

  bank_state_e              state_q [NB];
  bank_state_e              state_d [NB];
  logic [TW-1:0]            timer_q [NB];
  logic [TW-1:0]            timer_d [NB];
  logic [ROW_BITS-1:0]      row_q   [NB];
  logic [ROW_BITS-1:0]      row_d   [NB];
  logic [ADDR_BITS-1:0]     mr_q    [4];
  logic [ADDR_BITS-1:0]     mr_d    [4];
  logic [3:0]               mr_wr_q, mr_wr_d;
  logic [TW-1:0]            mrd_q, mrd_d;
  logic                     init_q, init_d;

  logic                     is_cmd;
  logic [3:0]               code;
  logic [2:0]               err;
  logic                     all_idle;
  logic                     mrd_busy;
  bank_state_e              tgt;

  // Decode the pins and pick the lowest applicable error; bank rules only apply once init is done
  always_comb begin
    is_cmd   = cke && !cs_n && !(ras_n && cas_n && we_n);
    code     = {1'b0, ras_n, cas_n, we_n};
    tgt      = state_q[ba];
    mrd_busy = (mrd_q != '0);
    all_idle = 1'b1;
    for (int b = 0; b < NB; b++) begin
      if (state_q[b] != B_IDLE) all_idle = 1'b0;
    end
    err = 3'd0;
    if (!init_q && (code == C_REF || code == C_PRE || code == C_ACT || code == C_WR || code == C_RD)) begin
      err = 3'd4;
    end else begin
      case (code)
        C_ACT:       if (tgt != B_IDLE) err = 3'd1; else if (mrd_busy) err = 3'd3;
        C_WR, C_RD:  if (tgt != B_ACTIVE) err = 3'd2; else if (mrd_busy) err = 3'd3;
        C_MRS, C_REF: if (!all_idle || mrd_busy) err = 3'd3;
        C_PRE, C_ZQ: if (mrd_busy) err = 3'd3;
        default: ;
      endcase
    end
  end

  // Next state: timers count every cycle; a legal command overrides its bank's countdown
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      state_d[b] = state_q[b];
      timer_d[b] = timer_q[b];
      row_d[b]   = row_q[b];
      case (state_q[b])
        B_ACTIVATING: begin
          if (timer_q[b] <= TW'(1)) begin
            state_d[b] = B_ACTIVE;
            timer_d[b] = '0;
          end else begin
            timer_d[b] = timer_q[b] - TW'(1);
          end
        end
        B_PRECHARGING: begin
          if (timer_q[b] <= TW'(1)) begin
            state_d[b] = B_IDLE;
            timer_d[b] = '0;
          end else begin
            timer_d[b] = timer_q[b] - TW'(1);
          end
        end
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) mr_d[i] = mr_q[i];
    mr_wr_d = mr_wr_q;
    init_d  = init_q;
    mrd_d   = mrd_busy ? mrd_q - TW'(1) : '0;
    if (is_cmd && err == 3'd0) begin
      case (code)
        C_MRS: begin
          mr_d[ba[1:0]]    = addr;
          mr_wr_d[ba[1:0]] = 1'b1;
          mrd_d            = TW'(TMRD - 1);
        end
        C_ACT: begin
          row_d[ba]   = addr[ROW_BITS-1:0];
          state_d[ba] = (TRCD > 1) ? B_ACTIVATING : B_ACTIVE;
          timer_d[ba] = TW'(TRCD - 1);
        end
        C_PRE: begin
          for (int b = 0; b < NB; b++) begin
            if ((addr[10] || BA_BITS'(b) == ba) &&
                (state_q[b] == B_ACTIVATING || state_q[b] == B_ACTIVE)) begin
              state_d[b] = (TRP > 1) ? B_PRECHARGING : B_IDLE;
              timer_d[b] = TW'(TRP - 1);
            end
          end
        end
        C_WR, C_RD: begin
          if (addr[10]) begin
            state_d[ba] = (TRP > 1) ? B_PRECHARGING : B_IDLE;
            timer_d[ba] = TW'(TRP - 1);
          end
        end
        C_ZQ: if (addr[10] && (&mr_wr_q)) init_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Tracking state register
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= B_IDLE;
        timer_q[b] <= '0;
        row_q[b]   <= '0;
      end
      for (int i = 0; i < 4; i++) mr_q[i] <= '0;
      mr_wr_q <= '0;
      mrd_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_d[b];
        timer_q[b] <= timer_d[b];
        row_q[b]   <= row_d[b];
      end
      for (int i = 0; i < 4; i++) mr_q[i] <= mr_d[i];
      mr_wr_q <= mr_wr_d;
      mrd_q   <= mrd_d;
      init_q  <= init_d;
    end
  end

  // Registered command/error report; fields hold their last value between commands
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      cmd_valid <= is_cmd;
      err_valid <= is_cmd && (err != 3'd0);
      if (is_cmd) begin
        cmd_code <= code;
        cmd_ba   <= ba;
        cmd_addr <= addr;
        err_code <= err;
      end
    end
  end

  // Bank activity view and open row of the last reported bank
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bank_active[b] = (state_q[b] == B_ACTIVATING) || (state_q[b] == B_ACTIVE);
    end
    open_row = bank_active[cmd_ba] ? row_q[cmd_ba] : '0;
  end

  assign mr0       = mr_q[0];
  assign mr1       = mr_q[1];
  assign mr2       = mr_q[2];
  assign mr3       = mr_q[3];
  assign init_done = init_q;

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// tb/tb_ddr3_cmd_decoder.sv - directed scoreboard bench for ddr3_cmd_decoder
module tb_ddr3_cmd_decoder;

  localparam int BA_BITS   = 3;
  localparam int ADDR_BITS = 14;
  localparam int ROW_BITS  = 14;
  localparam int TRCD      = 6;
  localparam int TRP       = 6;
  localparam int TMRD      = 4;

  localparam logic [2:0] P_MRS = 3'b000;
  localparam logic [2:0] P_REF = 3'b001;
  localparam logic [2:0] P_PRE = 3'b010;
  localparam logic [2:0] P_ACT = 3'b011;
  localparam logic [2:0] P_RD  = 3'b101;
  localparam logic [2:0] P_ZQ  = 3'b110;
  localparam logic [2:0] P_NOP = 3'b111;

  logic                  ck = 1'b0;
  logic                  rst_n;
  logic                  cke;
  logic                  cs_n;
  logic                  ras_n;
  logic                  cas_n;
  logic                  we_n;
  logic [BA_BITS-1:0]    ba;
  logic [ADDR_BITS-1:0]  addr;
  logic                  cmd_valid;
  logic [3:0]            cmd_code;
  logic [BA_BITS-1:0]    cmd_ba;
  logic [ADDR_BITS-1:0]  cmd_addr;
  logic [ADDR_BITS-1:0]  mr0, mr1, mr2, mr3;
  logic [7:0]            bank_active;
  logic [ROW_BITS-1:0]   open_row;
  logic                  init_done;
  logic                  err_valid;
  logic [2:0]            err_code;

  typedef struct {
    string                 tag;
    logic                  cv;
    logic [3:0]            code;
    logic [BA_BITS-1:0]    b;
    logic [ADDR_BITS-1:0]  a;
    logic                  ev;
    logic [2:0]            ec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ddr3_cmd_decoder #(
    .BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS), .ROW_BITS(ROW_BITS),
    .TRCD(TRCD), .TRP(TRP), .TMRD(TMRD)
  ) dut (
    .ck(ck), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .mr0(mr0), .mr1(mr1), .mr2(mr2), .mr3(mr3),
    .bank_active(bank_active), .open_row(open_row), .init_done(init_done),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one pin pattern, queue its expected report, and compare after the sampling edge
  task automatic issue(input string tag, input logic c_ke, input logic c_sn, input logic [2:0] pins,
                       input logic [BA_BITS-1:0] b, input logic [ADDR_BITS-1:0] a,
                       input logic e_cv, input logic e_ev, input logic [2:0] e_ec);
    exp_t e;
    cke  = c_ke;
    cs_n = c_sn;
    {ras_n, cas_n, we_n} = pins;
    ba   = b;
    addr = a;
    e.tag = tag; e.cv = e_cv; e.code = {1'b0, pins}; e.b = b; e.a = a; e.ev = e_ev; e.ec = e_ec;
    sb.push_back(e);
    @(posedge ck);
    #1;
    e = sb.pop_front();
    chk({e.tag, "/cmd_valid"}, cmd_valid, e.cv);
    if (e.cv) begin
      chk({e.tag, "/cmd_code"}, cmd_code, e.code);
      chk({e.tag, "/cmd_ba"}, cmd_ba, e.b);
      chk({e.tag, "/cmd_addr"}, cmd_addr, e.a);
    end
    chk({e.tag, "/err_valid"}, err_valid, e.ev);
    if (e.ev) chk({e.tag, "/err_code"}, err_code, e.ec);
  endtask

  task automatic cmd(input string tag, input logic [2:0] pins, input logic [BA_BITS-1:0] b,
                     input logic [ADDR_BITS-1:0] a, input logic e_ev, input logic [2:0] e_ec);
    issue(tag, 1'b1, 1'b0, pins, b, a, 1'b1, e_ev, e_ec);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue("nop", 1'b1, 1'b0, P_NOP, '0, '0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic do_init();
    cmd("mrs_ba2", P_MRS, 3'd2, 14'h0008, 1'b0, 3'd0); nop(TMRD);
    cmd("mrs_ba3", P_MRS, 3'd3, 14'h0000, 1'b0, 3'd0); nop(TMRD);
    cmd("mrs_ba1", P_MRS, 3'd1, 14'h0044, 1'b0, 3'd0); nop(TMRD);
    cmd("mrs_ba0", P_MRS, 3'd0, 14'h1520, 1'b0, 3'd0); nop(TMRD);
    chk("init_before_zq", init_done, 1'b0);
    cmd("zqcl", P_ZQ, 3'd0, 14'h0400, 1'b0, 3'd0);
    chk("init_done", init_done, 1'b1);
    chk("mr0", mr0, 14'h1520);
    chk("mr1", mr1, 14'h0044);
    chk("mr2", mr2, 14'h0008);
    chk("mr3", mr3, 14'h0000);
  endtask

  initial begin
    rst_n = 1'b0; cke = 1'b0; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = '0; addr = '0;
    repeat (2) @(posedge ck);
    #1;
    chk("rst/cmd_valid", cmd_valid, 1'b0);
    chk("rst/err_valid", err_valid, 1'b0);
    chk("rst/bank_active", bank_active, 8'h00);
    chk("rst/init_done", init_done, 1'b0);
    chk("rst/open_row", open_row, 14'h0);
    rst_n = 1'b1;

    // Pre-init illegal command, then init and reset while a bank is activating
    cmd("pre_init_act", P_ACT, 3'd0, 14'h0001, 1'b1, 3'd4);
    do_init();
    cmd("act_b2", P_ACT, 3'd2, 14'h0155, 1'b0, 3'd0);
    chk("act_b2/bank_active", bank_active, 8'h04);
    chk("act_b2/open_row", open_row, 14'h0155);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst/cmd_valid", cmd_valid, 1'b0);
    chk("async_rst/cmd_code", cmd_code, 4'd0);
    chk("async_rst/cmd_addr", cmd_addr, 14'h0);
    chk("async_rst/bank_active", bank_active, 8'h00);
    chk("async_rst/init_done", init_done, 1'b0);
    chk("async_rst/mr0", mr0, 14'h0);
    chk("async_rst/open_row", open_row, 14'h0);
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    cmd("rd_after_rst", P_RD, 3'd2, 14'h0000, 1'b1, 3'd4);
    chk("rd_after_rst/bank_active", bank_active, 8'h00);

    do_init();

    // tRCD boundary on bank 3
    cmd("act_b3", P_ACT, 3'd3, 14'h1ABC, 1'b0, 3'd0);
    nop(TRCD - 2);
    cmd("rd_trcd_m1", P_RD, 3'd3, 14'h0010, 1'b1, 3'd2);
    cmd("rd_trcd", P_RD, 3'd3, 14'h0020, 1'b0, 3'd0);
    chk("rd_trcd/open_row", open_row, 14'h1ABC);
    chk("rd_trcd/bank_active", bank_active, 8'h08);

    // Back-to-back ACT on bank 1
    cmd("act_b1", P_ACT, 3'd1, 14'h0777, 1'b0, 3'd0);
    cmd("act_b1_again", P_ACT, 3'd1, 14'h0123, 1'b1, 3'd1);
    chk("act_b1_again/open_row", open_row, 14'h0777);
    chk("act_b1_again/bank_active", bank_active, 8'h0A);

    // Precharge-all and REF across the tRP boundary
    cmd("act_b0", P_ACT, 3'd0, 14'h0010, 1'b0, 3'd0);
    cmd("act_b5", P_ACT, 3'd5, 14'h0020, 1'b0, 3'd0);
    chk("act_b5/bank_active", bank_active, 8'h2B);
    cmd("pre_all", P_PRE, 3'd0, 14'h0400, 1'b0, 3'd0);
    chk("pre_all/bank_active", bank_active, 8'h00);
    nop(TRP - 2);
    cmd("ref_trp_m1", P_REF, 3'd0, 14'h0000, 1'b1, 3'd3);
    cmd("ref_trp", P_REF, 3'd0, 14'h0000, 1'b0, 3'd0);
    chk("ref_trp/bank_active", bank_active, 8'h00);

    // tMRD violation, DES and cke=0
    cmd("mrs_b3", P_MRS, 3'd3, 14'h0004, 1'b0, 3'd0);
    nop(1);
    cmd("mrs_tmrd", P_MRS, 3'd3, 14'h0055, 1'b1, 3'd3);
    chk("mrs_tmrd/mr3", mr3, 14'h0004);
    issue("cke_low_act", 1'b0, 1'b0, P_ACT, 3'd2, 14'h0099, 1'b0, 1'b0, 3'd0);
    issue("des_act", 1'b1, 1'b1, P_ACT, 3'd2, 14'h0099, 1'b0, 1'b0, 3'd0);
    chk("cke_low/bank_active", bank_active, 8'h00);
    nop(1);

    // Auto-precharge read and re-activation exactly tRP later
    cmd("act_b6", P_ACT, 3'd6, 14'h0333, 1'b0, 3'd0);
    nop(TRCD - 1);
    cmd("rda_b6", P_RD, 3'd6, 14'h0400, 1'b0, 3'd0);
    chk("rda_b6/bank_active", bank_active, 8'h00);
    chk("rda_b6/open_row", open_row, 14'h0);
    nop(TRP - 1);
    cmd("act_b6_trp", P_ACT, 3'd6, 14'h0444, 1'b0, 3'd0);
    chk("act_b6_trp/bank_active", bank_active, 8'h40);
    chk("act_b6_trp/open_row", open_row, 14'h0444);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
